// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: state encoding,
// saturating-count width and its increment helper.
package pll_seq_pkg;

    localparam int SAT_W = 8;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (&v) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic two-flop synchroniser with async active-low reset
// and a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock qualification sequencer on the reference clock.
// Optional lock-loss counter: define PLL_SEQ_LOSS_COUNT_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRIES  = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pll_lock_i,
    output logic             pll_reset_o,
    output logic             sys_rst_no,
    output logic             locked_o,
    output logic             fault_o,
    output logic [SAT_W-1:0] retries_o,
    output logic [SAT_W-1:0] loss_count_o
);

    localparam int MAX_AB  = (RESET_CYCLES > LOCK_STABLE) ? RESET_CYCLES : LOCK_STABLE;
    localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_DONE = CNT_W'(LOCK_STABLE);
    localparam bit FAST_QUAL = (LOCK_STABLE == 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] stable_q, stable_d;
    logic [SAT_W-1:0] retries_q, retries_d;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    logic             lock_s;
    logic             fail;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (pll_lock_i),
        .q_o     (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        stable_d  = stable_q;
        retries_d = retries_q;
        fail      = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + CNT_W'(1);
                if (lock_s && FAST_QUAL) begin
                    state_d = ST_RUN;
                end else if (timer_q == TMO_LAST) begin
                    fail = 1'b1;
                end else if (lock_s) begin
                    state_d  = ST_STABLE;
                    stable_d = CNT_W'(1);
                end
            end
            ST_STABLE: begin
                timer_d = timer_q + CNT_W'(1);
                if (lock_s) begin
                    stable_d = stable_q + CNT_W'(1);
                    // qualification beats a same-cycle timeout
                    if (stable_d == STB_DONE) begin
                        state_d = ST_RUN;
                    end else if (timer_q == TMO_LAST) begin
                        fail = 1'b1;
                    end
                end else begin
                    stable_d = '0;
                    if (timer_q == TMO_LAST) begin
                        fail = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_RESET;
                timer_d = '0;
            end
        endcase

        if (fail) begin
            retries_d = sat_inc(retries_q);
            timer_d   = '0;
            stable_d  = '0;
            if (MAX_RETRIES != 0 && int'(retries_d) == MAX_RETRIES) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_RESET;
            end
        end

        pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
        sys_rst_n_d = (state_d == ST_RUN);
        locked_d    = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESET;
            timer_q     <= '0;
            stable_q    <= '0;
            retries_q   <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stable_q    <= stable_d;
            retries_q   <= retries_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic             lost;
    logic [SAT_W-1:0] loss_q, loss_d;

    assign lost = (state_q == ST_RUN) && !lock_s;

    always_comb begin
        loss_d = loss_q;
        if (lost) begin
            loss_d = sat_inc(loss_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_count_o = loss_q;
`else
    assign loss_count_o = '0;
`endif

    assign pll_reset_o = pll_reset_q;
    assign sys_rst_no  = sys_rst_n_q;
    assign locked_o    = locked_q;
    assign fault_o     = fault_q;
    assign retries_o   = retries_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed + randomized bench for pll_lock_sequencer with a
// phase-level reference model of the lock handshake.
module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int MR = 2;

    localparam int P_PULSE = 0;
    localparam int P_ACQ   = 1;
    localparam int P_RUN   = 2;
    localparam int P_FAULT = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       pll_reset_o;
    logic       sys_rst_no;
    logic       locked_o;
    logic       fault_o;
    logic [7:0] retries_o;
    logic [7:0] loss_count_o;

    int checks = 0;
    int failures = 0;

    int phase;
    int pulse_done;
    int waited;
    int run_len;
    int m_retries;
    int m_losses;
    bit lk_q[$];

    pll_lock_sequencer #(
        .RESET_CYCLES (RC),
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (LT),
        .MAX_RETRIES  (MR)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pll_lock_i   (pll_lock_i),
        .pll_reset_o  (pll_reset_o),
        .sys_rst_no   (sys_rst_no),
        .locked_o     (locked_o),
        .fault_o      (fault_o),
        .retries_o    (retries_o),
        .loss_count_o (loss_count_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        phase      = P_PULSE;
        pulse_done = 0;
        waited     = 0;
        run_len    = 0;
        m_retries  = 0;
        m_losses   = 0;
        lk_q.delete();
        lk_q.push_back(1'b0);
        lk_q.push_back(1'b0);
    endtask

    // One reference-clock edge of the handshake, seen through the 2-cycle sync delay.
    task automatic model_step(input bit seen);
        case (phase)
            P_PULSE: begin
                pulse_done++;
                if (pulse_done == RC) begin
                    phase   = P_ACQ;
                    waited  = 0;
                    run_len = 0;
                end
            end
            P_ACQ: begin
                waited++;
                run_len = seen ? run_len + 1 : 0;
                if (run_len == LS) begin
                    phase = P_RUN;
                end else if (waited == LT) begin
                    m_retries = (m_retries < 255) ? m_retries + 1 : 255;
                    if (MR != 0 && m_retries == MR) begin
                        phase = P_FAULT;
                    end else begin
                        phase      = P_PULSE;
                        pulse_done = 0;
                    end
                end
            end
            P_RUN: begin
                if (!seen) begin
                    phase      = P_PULSE;
                    pulse_done = 0;
                    if (m_losses < 255) m_losses++;
                end
            end
            default: begin
            end
        endcase
    endtask

    function automatic int exp_loss();
`ifdef PLL_SEQ_LOSS_COUNT_EN
        return m_losses;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs();
        chk("pll_reset", 32'(pll_reset_o), 32'(phase == P_PULSE || phase == P_FAULT));
        chk("sys_rst_n", 32'(sys_rst_no), 32'(phase == P_RUN));
        chk("locked", 32'(locked_o), 32'(phase == P_RUN));
        chk("fault", 32'(fault_o), 32'(phase == P_FAULT));
        chk("retries", 32'(retries_o), 32'(m_retries));
        chk("loss_count", 32'(loss_count_o), 32'(exp_loss()));
    endtask

    task automatic tick(input bit lk);
        bit seen;
        pll_lock_i = lk;
        @(posedge clock);
        seen = lk_q.pop_front();
        lk_q.push_back(lk);
        model_step(seen);
        @(negedge clock);
        check_outputs();
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_reset_o;
            1:       return sys_rst_no;
            2:       return fault_o;
            default: return locked_o;
        endcase
    endfunction

    task automatic run_until(input bit lk, input int sel, input bit val,
                             input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick(lk);
            if (sig(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_pll_reset", 32'(pll_reset_o), 32'd1);
        chk("rst_sys_rst_n", 32'(sys_rst_no), 32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_retries", 32'(retries_o), 32'd0);
        chk("rst_loss", 32'(loss_count_o), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        model_reset();
        @(negedge clock);
        do_reset();

        // clean lock
        run_until(1'b0, 0, 1'b0, 20, n);
        chk("pulse_len", 32'(n), 32'd4);
        tick(1'b0);
        tick(1'b0);
        run_until(1'b1, 1, 1'b1, 60, n);
        chk("qual_latency", 32'(n), 32'd10);
        chk("clean_retries", 32'(retries_o), 32'd0);

        // lock loss in RUN: 4-cycle drop
        run_until(1'b0, 1, 1'b0, 10, n);
        chk("loss_latency", 32'(n), 32'd3);
        tick(1'b0);
        run_until(1'b1, 0, 1'b0, 20, n);
        chk("repulse_len", 32'(n), 32'd3);
        chk("loss_count_1", 32'(loss_count_o), 32'(exp_loss()));
        run_until(1'b1, 3, 1'b1, 80, n);
        chk("relock_latency", 32'(n), 32'd8);

        // async reset mid-STABLE
        do_reset();
        run_until(1'b0, 0, 1'b0, 20, n);
        chk("pulse_len_2", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) tick(1'b1);
        do_reset();
        run_until(1'b1, 0, 1'b0, 20, n);
        chk("restart_pulse", 32'(n), 32'd4);
        run_until(1'b1, 1, 1'b1, 60, n);
        chk("restart_qual", 32'(n), 32'd8);

        // bouncy lock
        do_reset();
        run_until(1'b0, 0, 1'b0, 20, n);
        chk("pulse_len_3", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) tick(1'b1);
        tick(1'b0);
        run_until(1'b1, 1, 1'b1, 60, n);
        chk("bounce_qual", 32'(n), 32'd10);

        // timeout and fault
        do_reset();
        run_until(1'b0, 0, 1'b0, 20, n);
        chk("pulse_len_4", 32'(n), 32'd4);
        run_until(1'b0, 0, 1'b1, 60, n);
        chk("timeout_len", 32'(n), 32'd32);
        chk("retries_1", 32'(retries_o), 32'd1);
        run_until(1'b0, 0, 1'b0, 20, n);
        chk("pulse_len_5", 32'(n), 32'd4);
        run_until(1'b0, 2, 1'b1, 60, n);
        chk("fault_len", 32'(n), 32'd32);
        chk("retries_2", 32'(retries_o), 32'd2);
        for (int i = 0; i < 40; i++) tick(1'($urandom_range(0, 1)));
        chk("fault_hold", 32'(pll_reset_o), 32'd1);

        // randomized lock waveforms against the model
        for (int ep = 0; ep < 6; ep++) begin
            int left;
            bit lk;
            do_reset();
            left = 0;
            lk = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (left == 0) begin
                    lk   = ($urandom_range(0, 3) != 0);
                    left = lk ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 6));
                end
                tick(lk);
                left--;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
